load_port_arbiter: RTL and testbench

LOAD_PORT_ARBITER -- requirements
Module: load_port_arbiter

---
 rtl/load_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_load_port_arbiter.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_port_arbiter.sv
// Load port arbiter: shares one dcache read port between NUM_REQ load FUs.
// One load is in flight at a time. The FSM steps IDLE -> WAIT -> RESP.
// Requests are granted round-robin. A load is abandoned on flush or when
// the dcache has not hit after TIMEOUT cycles of waiting.

`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif

module load_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = `SYS_XLEN,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      ld_req,
    input  logic [NUM_REQ*XLEN-1:0] ld_addr,
    output logic [NUM_REQ-1:0]      ld_gnt,
    output logic [NUM_REQ-1:0]      ld_resp_valid,
    output logic [XLEN-1:0]         ld_resp_data,
    output logic                    dc_rd_en,
    output logic [XLEN-1:0]         dc_addr,
    input  logic [XLEN-1:0]         dc_data_in,
    input  logic                    dc_hit,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Value the wait counter holds during the last WAIT cycle before an abort.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;     // first FU considered at the next arbitration
    logic [PTR_W-1:0]   owner;      // FU whose load is in flight
    logic [CNT_W-1:0]   wait_cnt;   // WAIT cycles already spent without a hit
    logic [XLEN-1:0]    addr_q;     // address of the in-flight load
    logic [XLEN-1:0]    data_q;     // data captured on the dcache hit
    logic [XLEN-1:0]    last_data;  // value of the last delivered response

    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic               resp_fire;

    // Returns (base + offs) mod NUM_REQ. offs is at most NUM_REQ, so one
    // conditional subtraction is enough and no divider is needed.
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int               offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin search: first requesting FU at or after rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first. Otherwise a
        // path that skips the assignment makes synthesis infer a latch.
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && ld_req[wrap_idx(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Grant pulse. It is only raised in IDLE when no flush is present.
    // rst_n gates the grant so that it stays low during reset while requests
    // are still held.
    always_comb begin
        ld_gnt = '0;
        if (rst_n && (state == ST_IDLE) && !flush && pick_valid) begin
            ld_gnt[pick_idx] = 1'b1;
        end
    end

    // The response pulse follows the registered RESP state. A flush in the
    // same cycle suppresses it.
    assign resp_fire = (state == ST_RESP) && !flush;

    // Response routing to the owner. Between responses the data port shows
    // the last delivered value.
    always_comb begin
        ld_resp_valid = '0;
        if (resp_fire) begin
            ld_resp_valid[owner] = 1'b1;
        end
    end

    assign ld_resp_data = resp_fire ? data_q : last_data;

    // The dcache port is driven only while waiting. It is zero otherwise.
    assign dc_rd_en = (state == ST_WAIT);
    assign dc_addr  = (state == ST_WAIT) ? addr_q : '0;
    assign busy     = (state != ST_IDLE);

    // Main FSM: arbitration, dcache wait, response, timeout and flush handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Address and data holding registers are reset as well. Their
            // contents reach output ports, and those ports must read zero
            // after reset.
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            wait_cnt    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. That
            // way every register samples the values from before this edge.
            timeout_err <= 1'b0;
            if (flush) begin
                // Squash: drop the in-flight load and leave rr_ptr alone, so
                // the same FU wins again if it still requests.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pick_valid) begin
                            owner    <= pick_idx;
                            addr_q   <= ld_addr[int'(pick_idx)*XLEN +: XLEN];
                            wait_cnt <= '0;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (dc_hit) begin
                            data_q <= dc_data_in;
                            state  <= ST_RESP;
                        end else if (wait_cnt == CNT_LAST) begin
                            // TIMEOUT miss cycles have passed: abort and
                            // move past this owner.
                            timeout_err <= 1'b1;
                            rr_ptr      <= wrap_idx(owner, 1);
                            state       <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_RESP: begin
                        last_data <= data_q;
                        rr_ptr    <= wrap_idx(owner, 1);
                        state     <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_port_arbiter.sv
// Testbench for load_port_arbiter.
// It contains directed scenarios plus a randomized run. Expected values come
// from a transaction-level model kept in this file.

module tb_load_port_arbiter;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int TO   = 4;

    localparam int P_IDLE = 0;
    localparam int P_WAIT = 1;
    localparam int P_RESP = 2;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic [N-1:0]      ld_req;
    logic [N*XLEN-1:0] ld_addr;
    logic [N-1:0]      ld_gnt;
    logic [N-1:0]      ld_resp_valid;
    logic [XLEN-1:0]   ld_resp_data;
    logic              dc_rd_en;
    logic [XLEN-1:0]   dc_addr;
    logic [XLEN-1:0]   dc_data_in;
    logic              dc_hit;
    logic              busy;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    // Model state
    int              m_phase;
    int              m_ptr;
    int              m_owner;
    int              m_waits;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_data;
    logic [XLEN-1:0] m_last;
    logic            m_terr;

    // Model expectations for the current cycle
    logic [N-1:0]    e_gnt;
    logic [N-1:0]    e_rv;
    logic [XLEN-1:0] e_rdata;
    logic            e_rd;
    logic [XLEN-1:0] e_addr;
    logic            e_busy;
    logic            e_terr;
    logic [N-1:0]    last_gnt;

    load_port_arbiter #(
        .NUM_REQ(N),
        .XLEN   (XLEN),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_gnt       (ld_gnt),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data (ld_resp_data),
        .dc_rd_en     (dc_rd_en),
        .dc_addr      (dc_addr),
        .dc_data_in   (dc_data_in),
        .dc_hit       (dc_hit),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_ptr   = 0;
        m_owner = 0;
        m_waits = 0;
        m_addr  = '0;
        m_data  = '0;
        m_last  = '0;
        m_terr  = 1'b0;
    endtask

    // Expected outputs from the model state and the present inputs.
    task automatic model_eval();
        e_gnt = '0;
        if (rst_n === 1'b1 && m_phase == P_IDLE && !flush) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (ld_req[i] && e_gnt == '0) e_gnt[i] = 1'b1;
            end
        end
        e_rd   = (m_phase == P_WAIT);
        e_addr = e_rd ? m_addr : '0;
        e_rv   = '0;
        if (m_phase == P_RESP && !flush) e_rv[m_owner] = 1'b1;
        e_rdata = (e_rv != '0) ? m_data : m_last;
        e_busy  = (m_phase != P_IDLE);
        e_terr  = m_terr;
    endtask

    // Model step at a rising edge, using the inputs held across that edge.
    task automatic model_update();
        model_eval();
        m_terr = 1'b0;
        if (flush) begin
            m_phase = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (e_gnt != '0) begin
                for (int i = 0; i < N; i++) if (e_gnt[i]) m_owner = i;
                m_addr  = ld_addr[m_owner*XLEN +: XLEN];
                m_waits = 0;
                m_phase = P_WAIT;
            end
        end else if (m_phase == P_WAIT) begin
            if (dc_hit) begin
                m_data  = dc_data_in;
                m_phase = P_RESP;
            end else begin
                m_waits = m_waits + 1;
                if (m_waits == TO) begin
                    m_terr  = 1'b1;
                    m_ptr   = (m_owner + 1) % N;
                    m_phase = P_IDLE;
                end
            end
        end else begin
            m_last  = m_data;
            m_ptr   = (m_owner + 1) % N;
            m_phase = P_IDLE;
        end
    endtask

    // Advance one clock. Inputs were set after the previous falling edge.
    task automatic tick();
        model_eval();
        last_gnt = e_gnt;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        ld_req     = '0;
        ld_addr    = '0;
        dc_hit     = 1'b0;
        dc_data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ld_req     = 2'b11;
        dc_hit     = 1'b1;
        dc_data_in = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        checks++;
        if ({ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt=%b rv=%b data=%h rd=%b addr=%h busy=%b terr=%b, all zero required",
                     ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err);
        end
        do_reset();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_hit();
        do_reset();
        ld_req              = 2'b01;
        ld_addr[0 +: XLEN]  = 32'h1000_0008;
        #1;
        checks++;
        if (ld_gnt !== 2'b01) begin
            failures++;
            $display("FAIL single_gnt: got %b want 01", ld_gnt);
        end
        tick();
        ld_req     = 2'b00;
        dc_hit     = 1'b1;
        dc_data_in = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (dc_rd_en !== 1'b1 || dc_addr !== 32'h1000_0008) begin
            failures++;
            $display("FAIL single_dc_addr: rd=%b addr=%h want 1 10000008", dc_rd_en, dc_addr);
        end
        tick();
        dc_hit = 1'b0;
        #1;
        checks++;
        if (ld_resp_valid !== 2'b01 || ld_resp_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single_resp: rv=%b data=%h want 01 deadbeef", ld_resp_valid, ld_resp_data);
        end
        tick();
        #1;
        checks++;
        if (ld_resp_valid !== 2'b00 || ld_resp_data !== 32'hDEAD_BEEF || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: rv=%b data=%h busy=%b want 00 deadbeef 0",
                     ld_resp_valid, ld_resp_data, busy);
        end
    endtask

    task automatic test_alternate();
        int g = 0;
        int r = 0;
        do_reset();
        ld_req                = 2'b11;
        ld_addr[0 +: XLEN]    = 32'h0000_A000;
        ld_addr[XLEN +: XLEN] = 32'h0000_B000;
        dc_hit                = 1'b1;
        for (int c = 0; c < 12; c++) begin
            dc_data_in = 32'hC0DE_0000 + 32'(g);
            #1;
            if (ld_gnt != '0) begin
                checks++;
                if (ld_gnt !== 2'(1 << (g % 2))) begin
                    failures++;
                    $display("FAIL alt_gnt%0d: got %b want %b", g, ld_gnt, 2'(1 << (g % 2)));
                end
                g++;
            end
            if (ld_resp_valid != '0) begin
                checks++;
                if (ld_resp_valid !== 2'(1 << (r % 2)) || ld_resp_data !== 32'hC0DE_0000 + 32'(r + 1)) begin
                    failures++;
                    $display("FAIL alt_resp%0d: rv=%b data=%h want %b %h", r, ld_resp_valid,
                             ld_resp_data, 2'(1 << (r % 2)), 32'hC0DE_0000 + 32'(r + 1));
                end
                r++;
            end
            tick();
        end
        checks++;
        if (g != 4 || r != 4) begin
            failures++;
            $display("FAIL alt_count: grants=%0d resps=%0d want 4 4", g, r);
        end
        ld_req = '0;
        dc_hit = 1'b0;
    endtask

    task automatic test_slow_hit();
        int rd = 0;
        do_reset();
        ld_req                = 2'b10;
        ld_addr[XLEN +: XLEN] = 32'h2000_0040;
        #1;
        checks++;
        if (ld_gnt !== 2'b10) begin
            failures++;
            $display("FAIL slow_gnt: got %b want 10", ld_gnt);
        end
        tick();
        ld_req = '0;
        for (int c = 0; c < 4; c++) begin
            dc_hit     = (c == 3);
            dc_data_in = (c == 3) ? 32'h1122_3344 : 32'h0BAD_0BAD;
            #1;
            if (dc_rd_en) rd++;
            tick();
        end
        dc_hit = 1'b0;
        #1;
        checks++;
        if (rd != 4 || ld_resp_valid !== 2'b10 || ld_resp_data !== 32'h1122_3344) begin
            failures++;
            $display("FAIL slow_resp: rd_cycles=%0d rv=%b data=%h want 4 10 11223344",
                     rd, ld_resp_valid, ld_resp_data);
        end
        tick();
    endtask

    task automatic test_flush_hit();
        do_reset();
        ld_req                = 2'b11;
        ld_addr[0 +: XLEN]    = 32'h0000_3000;
        ld_addr[XLEN +: XLEN] = 32'h0000_4000;
        #1;
        checks++;
        if (ld_gnt !== 2'b01) begin
            failures++;
            $display("FAIL flush_first_gnt: got %b want 01", ld_gnt);
        end
        tick();
        flush      = 1'b1;
        dc_hit     = 1'b1;
        dc_data_in = 32'hAAAA_AAAA;
        #1;
        tick();
        flush  = 1'b0;
        dc_hit = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || ld_resp_valid !== 2'b00 || ld_gnt !== 2'b01) begin
            failures++;
            $display("FAIL flush_after: busy=%b rv=%b gnt=%b want 0 00 01", busy, ld_resp_valid, ld_gnt);
        end
        tick();
        ld_req     = 2'b10;
        dc_hit     = 1'b1;
        dc_data_in = 32'h55AA_55AA;
        #1;
        tick();
        dc_hit = 1'b0;
        #1;
        checks++;
        if (ld_resp_valid !== 2'b01 || ld_resp_data !== 32'h55AA_55AA) begin
            failures++;
            $display("FAIL flush_regrant_resp: rv=%b data=%h want 01 55aa55aa", ld_resp_valid, ld_resp_data);
        end
        tick();
        #1;
        checks++;
        if (ld_gnt !== 2'b10) begin
            failures++;
            $display("FAIL flush_next_gnt: got %b want 10", ld_gnt);
        end
        tick();
        ld_req = '0;
    endtask

    task automatic test_timeout();
        int  n    = 0;
        bit  seen = 0;
        bit  resp = 0;
        do_reset();
        ld_req             = 2'b01;
        ld_addr[0 +: XLEN] = 32'h0000_5000;
        #1;
        tick();
        ld_req = '0;
        dc_hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (timeout_err) begin
                seen = 1;
                break;
            end
            if (dc_rd_en) n++;
            if (ld_resp_valid != '0) resp = 1;
            tick();
        end
        checks++;
        if (!seen || n != TO || resp || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_abort: seen=%0d wait_cycles=%0d resp=%0d busy=%b want 1 %0d 0 0",
                     seen, n, resp, busy, TO);
        end
        tick();
        ld_req = 2'b11;
        #1;
        checks++;
        if (timeout_err !== 1'b0 || ld_gnt !== 2'b10) begin
            failures++;
            $display("FAIL timeout_after: terr=%b gnt=%b want 0 10", timeout_err, ld_gnt);
        end
        tick();
        ld_req = '0;
    endtask

    task automatic test_reset_mid_wait();
        bit bad = 0;
        do_reset();
        ld_req                = 2'b10;
        ld_addr[XLEN +: XLEN] = 32'h0000_6000;
        #1;
        tick();
        ld_req = 2'b11;
        tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err} !== '0) begin
            failures++;
            $display("FAIL midwait_reset: gnt=%b rv=%b data=%h rd=%b addr=%h busy=%b terr=%b, all zero required",
                     ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        ld_req = '0;
        dc_hit = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ld_resp_valid !== 2'b00 || busy !== 1'b0) bad = 1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midwait_no_resp: activity seen after reset release, none required");
        end
        ld_req = 2'b11;
        #1;
        checks++;
        if (ld_gnt !== 2'b01) begin
            failures++;
            $display("FAIL midwait_first_gnt: got %b want 01", ld_gnt);
        end
        tick();
        ld_req = '0;
        dc_hit = 1'b0;
    endtask

    task automatic test_single_requester();
        int g = 0;
        do_reset();
        ld_req                = 2'b10;
        ld_addr[XLEN +: XLEN] = 32'h0000_7000;
        dc_hit                = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (ld_gnt != '0) begin
                checks++;
                if (ld_gnt !== 2'b10) begin
                    failures++;
                    $display("FAIL solo_gnt%0d: got %b want 10", g, ld_gnt);
                end
                g++;
            end
            tick();
        end
        checks++;
        if (g != 3) begin
            failures++;
            $display("FAIL solo_count: grants=%0d want 3", g);
        end
        ld_req = '0;
        dc_hit = 1'b0;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!ld_req[i] && ($urandom % 3 == 0)) begin
                    ld_req[i]               = 1'b1;
                    ld_addr[i*XLEN +: XLEN] = $urandom;
                end
            end
            flush      = ($urandom % 16 == 0);
            dc_hit     = ($urandom % 5 < 2);
            dc_data_in = $urandom;
            #1;
            model_eval();
            checks++;
            if ({ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err} !==
                {e_gnt, e_rv, e_rdata, e_rd, e_addr, e_busy, e_terr}) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: gnt=%b rv=%b data=%h rd=%b addr=%h busy=%b terr=%b want %b %b %h %b %h %b %b",
                             c, ld_gnt, ld_resp_valid, ld_resp_data, dc_rd_en, dc_addr, busy, timeout_err,
                             e_gnt, e_rv, e_rdata, e_rd, e_addr, e_busy, e_terr);
            end
            tick();
            ld_req = ld_req & ~last_gnt;
        end
        flush  = 1'b0;
        dc_hit = 1'b0;
        ld_req = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        ld_req     = '0;
        ld_addr    = '0;
        dc_hit     = 1'b0;
        dc_data_in = '0;
        last_gnt   = '0;
        model_reset();
        test_reset();
        test_single_hit();
        test_alternate();
        test_slow_hit();
        test_flush_hit();
        test_timeout();
        test_reset_mid_wait();
        test_single_requester();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
